// File: rtl/alu_pkg.sv
// Shared definitions for the ALU instruction sequencer: op_func codes,
// legality/multiply decode and the controller state encoding.
package alu_pkg;

  localparam int OPF_W = 6;

  typedef logic [OPF_W-1:0] op_func_t;

  // {op_code, func_code} encodings understood by the ALU
  localparam op_func_t OPF_ADD  = 6'b000000;
  localparam op_func_t OPF_SUB  = 6'b000001;
  localparam op_func_t OPF_AND  = 6'b000010;
  localparam op_func_t OPF_OR   = 6'b000011;
  localparam op_func_t OPF_XOR  = 6'b000100;
  localparam op_func_t OPF_SLT  = 6'b010000;
  localparam op_func_t OPF_MULU = 6'b010001;
  localparam op_func_t OPF_MULS = 6'b010010;
  localparam op_func_t OPF_SLL  = 6'b010100;
  localparam op_func_t OPF_SRL  = 6'b010101;
  localparam op_func_t OPF_SRA  = 6'b010110;
  localparam op_func_t OPF_NOR  = 6'b010111;
  localparam op_func_t OPF_SLTU = 6'b011000;
  localparam op_func_t OPF_ROL  = 6'b011001;
  localparam op_func_t OPF_ROR  = 6'b011010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB_LO = 3'd3,
    ST_WB_HI = 3'd4
  } state_t;

  // Per-instruction control captured at the handshake
  typedef struct packed {
    logic [1:0] op_code;
    logic [3:0] func_code;
    logic       illegal;
    logic       mul;
  } instr_ctl_t;

  function automatic logic is_legal(input op_func_t f);
    case (f)
      OPF_ADD, OPF_SUB, OPF_AND, OPF_OR, OPF_XOR,
      OPF_SLT, OPF_MULU, OPF_MULS, OPF_SLL, OPF_SRL,
      OPF_SRA, OPF_NOR, OPF_SLTU, OPF_ROL, OPF_ROR: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  function automatic logic is_mul(input op_func_t f);
    return (f == OPF_MULU) || (f == OPF_MULS);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// One-instruction-at-a-time ALU sequencer: read operands, run the external
// combinational ALU, write LOW (and HIGH for multiplies) back to the RF.
import alu_pkg::*;

module alu_seq_ctrl #(
  parameter int REG_AW  = 5,
  parameter int HI_REG  = 31,
  parameter bit ZERO_RO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        op_code,
  input  logic [3:0]        func_code,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [31:0]       rf_rdata_a,
  input  logic [31:0]       rf_rdata_b,
  output logic [1:0]        alu_op_code,
  output logic [3:0]        alu_func_code,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_low,
  input  logic [31:0]       alu_high,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              done,
  output logic              illegal,
  output logic              flag_zero,
  output logic              flag_neg
);

  localparam logic [REG_AW-1:0] HI_ADDR = HI_REG[REG_AW-1:0];

  state_t            state, state_nxt;
  instr_ctl_t        ctl_q;
  logic [REG_AW-1:0] rs_q, rt_q, rd_q;
  logic [31:0]       low_q, high_q;
  logic              wr_en;
  logic              accept;
  op_func_t          op_func;

  assign op_func = {op_code, func_code};
  assign accept  = (state == ST_IDLE) && instr_valid;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: illegal instructions bypass READ/EXEC and retire from WB_LO
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (instr_valid) state_nxt = is_legal(op_func) ? ST_READ : ST_WB_LO;
      ST_READ:  state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = ST_WB_LO;
      ST_WB_LO: state_nxt = (ctl_q.mul && !ctl_q.illegal) ? ST_WB_HI : ST_IDLE;
      ST_WB_HI: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Instruction latch; inputs need not be held once accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_q <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      rd_q  <= '0;
    end else if (accept) begin
      ctl_q.op_code   <= op_code;
      ctl_q.func_code <= func_code;
      ctl_q.illegal   <= !is_legal(op_func);
      ctl_q.mul       <= is_mul(op_func);
      rs_q            <= rs;
      rt_q            <= rt;
      rd_q            <= rd;
    end
  end

  // Operand capture in READ, result capture in EXEC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      low_q  <= '0;
      high_q <= '0;
    end else begin
      if (state == ST_READ) begin
        alu_a <= rf_rdata_a;
        alu_b <= rf_rdata_b;
      end
      if (state == ST_EXEC) begin
        low_q  <= alu_low;
        high_q <= alu_high;
      end
    end
  end

  // Status flags track the LOW result of the last legal retired instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_zero <= 1'b0;
      flag_neg  <= 1'b0;
    end else if (state == ST_WB_LO && !ctl_q.illegal) begin
      flag_zero <= (low_q == 32'd0);
      flag_neg  <= low_q[31];
    end
  end

  // ALU controls come straight from the latch so they stay stable READ..WB_HI
  assign alu_op_code   = ctl_q.op_code;
  assign alu_func_code = ctl_q.func_code;

  // Per-state outputs
  always_comb begin
    instr_ready = 1'b0;
    rf_raddr_a  = '0;
    rf_raddr_b  = '0;
    wr_en       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    unique case (state)
      ST_IDLE: instr_ready = 1'b1;
      ST_READ: begin
        rf_raddr_a = rs_q;
        rf_raddr_b = rt_q;
      end
      ST_EXEC: ;
      ST_WB_LO: begin
        if (ctl_q.illegal) begin
          done    = 1'b1;
          illegal = 1'b1;
        end else begin
          wr_en    = 1'b1;
          rf_waddr = rd_q;
          rf_wdata = low_q;
          done     = !ctl_q.mul;
        end
      end
      ST_WB_HI: begin
        wr_en    = 1'b1;
        rf_waddr = HI_ADDR;
        rf_wdata = high_q;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  // Register 0 may be read-only: the write is dropped but the instruction still retires
  assign rf_we = wr_en && !(ZERO_RO && (rf_waddr == '0));

endmodule
